// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, instruction field positions
// and the fetch-stage state encoding.
package mips_pkg;

   localparam int XLEN      = 32;
   localparam int INSTR_W   = 32;
   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int IMM_W     = 16;
   localparam int JIDX_W    = 26;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, PC-relative branch or
// pseudo-direct jump, with jump taking priority over branch.
module pc_next_logic
   import mips_pkg::*;
(
   input  logic [XLEN-1:0]   i_pc,
   input  logic [JIDX_W-1:0] i_jidx,
   input  logic              i_pc_src,
   input  logic              i_jump,
   output logic [XLEN-1:0]   o_pc_plus4,
   output logic [XLEN-1:0]   o_next_pc
);

   logic [XLEN-1:0] w_br_off;
   logic [XLEN-1:0] w_br_target;
   logic [XLEN-1:0] w_j_target;

   assign o_pc_plus4 = i_pc + XLEN'(4);

   // The branch immediate is the low half of the jump index field.
   assign w_br_off    = {{(XLEN-IMM_W-2){i_jidx[IMM_W-1]}}, i_jidx[IMM_W-1:0], 2'b00};
   assign w_br_target = o_pc_plus4 + w_br_off;
   assign w_j_target  = {o_pc_plus4[XLEN-1:JIDX_W+2], i_jidx, 2'b00};

   assign o_next_pc = i_jump   ? w_j_target  :
                      i_pc_src ? w_br_target :
                                 o_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per req/ready
// handshake, presents it to the controller and advances the PC on retire.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              CNT_W    = 32
)(
   input  logic               clk,
   input  logic               reset_n,
   output logic               imem_req,
   output logic [XLEN-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ack,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         instruc,
   output logic [5:0]         funct,
   input  logic               pc_src,
   input  logic               jump,
   output logic [XLEN-1:0]    pc,
   output logic [XLEN-1:0]    pc_plus4,
   output logic [CNT_W-1:0]   retired_cnt
);

   fetch_state_t       r_state;
   fetch_state_t       w_state_nxt;
   logic [XLEN-1:0]    r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic [CNT_W-1:0]   r_retired_cnt;
   logic               w_capture;
   logic               w_retire;
   logic [XLEN-1:0]    w_next_pc;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= RST;
      else          r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_retire    = 1'b0;
      unique case (r_state)
         RST:   w_state_nxt = FETCH;
         FETCH: begin
            if (imem_ready) begin
               w_capture   = 1'b1;
               w_state_nxt = VALID;
            end
         end
         VALID: begin
            if (instr_ack) begin
               w_retire    = 1'b1;
               w_state_nxt = FETCH;
            end
         end
         default: w_state_nxt = RST;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_retired_cnt <= '0;
      end else begin
         if (w_capture) r_instr <= imem_rdata;
         if (w_retire) begin
            r_pc          <= w_next_pc;
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
         end
      end
   end

   pc_next_logic u_pc_next (
      .i_pc       (r_pc),
      .i_jidx     (r_instr[JIDX_W-1:0]),
      .i_pc_src   (pc_src),
      .i_jump     (jump),
      .o_pc_plus4 (pc_plus4),
      .o_next_pc  (w_next_pc)
   );

   assign imem_req    = (r_state == FETCH);
   assign instr_valid = (r_state == VALID);
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign instr       = r_instr;
   assign instruc     = r_instr[OP_MSB:OP_LSB];
   assign funct       = r_instr[FUNCT_MSB:0];
   assign retired_cnt = r_retired_cnt;

   a_reset_pc_aligned: assert property (@(posedge clk) RESET_PC[1:0] == 2'b00)
      else $error("RESET_PC is not word-aligned");

   a_addr_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (imem_req && !imem_ready) |=> $stable(imem_addr))
      else $error("imem_addr changed while a request was pending");

   a_req_valid_excl: assert property (@(posedge clk) disable iff (!reset_n)
      !(imem_req && instr_valid))
      else $error("imem_req and instr_valid asserted together");

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the main controller and datapath of the MIPS core.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ready handshake.
- Presents the instruction, plus its opcode and funct fields, to the controller.
- On retirement, consumes the controller's pc_src/jump decisions to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of the fetch; always word-aligned.
- imem_ready  in  1  memory has imem_rdata valid this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr, instruc and funct hold a valid instruction.
- instr_ack  in  1  datapath retires the current instruction this cycle.
- instr  out  32  current instruction word.
- instruc  out  6  instr[31:26], to controller.
- funct  out  6  instr[5:0], to controller.
- pc_src  in  1  branch taken (controller); sampled only on retire.
- jump  in  1  jump (controller); sampled only on retire.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- retired_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State = RST, pc = RESET_PC, instr = 0, retired_cnt = 0.
  - imem_req = 0, instr_valid = 0.
  - All take effect immediately, regardless of clk.
- FSM states: RST, FETCH, VALID.
- RST -> FETCH on the first rising edge after reset_n deasserts. imem_req stays 0 while in RST.
- FETCH:
  - imem_req = 1 and imem_addr = pc, both held stable until the handshake.
  - On an edge with imem_ready = 1: instr <= imem_rdata, state -> VALID.
  - Minimum fetch latency is 1 cycle (ready in the first request cycle).
  - Unbounded wait is legal.
- VALID:
  - instr_valid = 1 and imem_req = 0.
  - instr_ack = 0: hold instr and pc unchanged indefinitely.
  - instr_ack = 1: pc <= next_pc, retired_cnt <= retired_cnt + 1 (wraps to 0 at all-ones), state -> FETCH.
  - Peak throughput is 1 instruction per 2 cycles.
- next_pc rules; priority is jump > pc_src > sequential:
  - jump = 1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else pc_src = 1: pc_plus4 + (sign_extend(instr[15:0]) << 2), modulo 2^32.
  - else: pc_plus4.
- Ignored inputs:
  - instr_ack outside VALID is ignored.
  - imem_ready outside FETCH is ignored.
  - pc_src and jump are ignored except on a retire edge.
- Boundaries:
  - PC wrap: pc = 32'hFFFF_FFFC with a sequential retire gives pc = 0.
  - Branch arithmetic wraps silently in both directions.
  - pc[1:0] is always 00; RESET_PC[1:0] ≠ 00 is illegal and is covered by an assertion.
- Reset mid-operation: reset_n low while in FETCH or VALID abandons the request immediately (imem_req = 0) and discards instr. There is no partial retire.
- Assertions:
  - imem_addr stable while imem_req=1 and imem_ready=0.
  - instr_valid and imem_req never both 1.

Decomposition:
- Shared package mips_pkg holds:
  - Fetch state enum fetch_state_t {RST, FETCH, VALID}.
  - Field constants: OP_MSB=31, OP_LSB=26, FUNCT_MSB=5, IMM_W=16, JIDX_W=26.
  - Width constants XLEN=32, INSTR_W=32.
- One sub-module: pc_next_logic, which is combinational and computes pc_plus4 and next_pc from pc, instr, pc_src and jump.
- The FSM, registers and counter stay in fetch_unit.

Test Plan:
- Reset then ready on the first cycle: imem_addr=0, imem_rdata=32'h2008_0005 -> one cycle later instr_valid=1, instruc=6'h08, funct=6'h05, pc=0.
- Sequential retire at pc=0x10 (jump=0, pc_src=0, instr_ack=1) -> next fetch addr 0x14, retired_cnt increments by 1.
- Branch: pc=0x100, instr=32'h1000_FFFE, pc_src=1 -> next pc = 0x104 - 8 = 0xFC. Jump: pc=0x4000_0000, instr=32'h0800_0010, jump=1 and pc_src=1 -> next pc = 0x4000_0040 (jump wins).
- Memory wait of 5 cycles: imem_addr stays stable and instr_valid=0 throughout; the word is captured on the 6th edge. Retire held off 3 cycles: instr and pc unchanged.
- Wrap: pc=32'hFFFF_FFFC, sequential retire -> imem_addr=0.
- Async reset asserted mid-FETCH with imem_req=1 -> imem_req=0 immediately; after release, fetch restarts at RESET_PC and retired_cnt=0.
